tag_store_nway: RTL and testbench
=================================

Name: tag_store_nway

Overview:
Parametrised N-way tag/state store for the L1 caches, the successor to the single-port tag RAM.
- Holds one tag plus MSI state per way per set.
- Clears itself to Invalid after reset with an internal sweep, replacing file preload.
- Performs a full associative lookup with hit detection and victim selection, one response cycle after a request.
- Sits between the cache controller FSM and the data RAMs.

Parameters:
AWIDTH, 3, set index width; DEPTH = 1<<AWIDTH sets
TWIDTH, 12, tag width in bits
WWIDTH, 1, way select width; WAYS = 1<<WWIDTH (WWIDTH >= 1)
SWIDTH, 2, coherence state width; encoding I=0, S=1, M=2, value 3 reserved (treated as valid)

Ports:
clock  in  1  system clock, rising edge active
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = write entry, 0 = lookup
req_index  in  AWIDTH  set index
req_tag  in  TWIDTH  tag to compare (lookup) or store (write)
req_way  in  WWIDTH  way to write (ignored on lookup)
req_state  in  SWIDTH  state to write (ignored on lookup)
init_done  out  1  high once the post-reset clear sweep has finished
resp_valid  out  1  lookup response valid
resp_hit  out  1  tag matched in a non-Invalid way
resp_way  out  WWIDTH  hitting way if hit, else victim way
resp_state  out  SWIDTH  state of hitting way; 0 on miss

Behaviour:
- Storage: DEPTH x WAYS entries of {tag, state}, plus a per-set round-robin pointer of WWIDTH bits.
- FSM has two states, INIT and RUN.
- Reset (asynchronous):
  - FSM goes to INIT and the sweep counter is set to 0.
  - init_done=0, req_ready=0, resp_valid=0, resp_hit=0, resp_way=0, resp_state=0.
- INIT:
  - One set per cycle: all ways of that set are written to state I, and the set's pointer is cleared to 0. Tags are don't-care.
  - After set DEPTH-1 is written, the FSM moves to RUN.
  - init_done and req_ready rise in the first cycle after the sweep, i.e. DEPTH cycles after reset deasserts.
  - Requests during INIT are ignored: no write occurs and no response is produced.
- RUN:
  - req_ready=1 continuously. A request is accepted on any rising edge with req_valid=1.
  - Sustained throughput is one request per cycle, lookups and writes in any mix.
- Write accepted at edge E:
  - Entry [req_index][req_way] takes {req_tag, req_state} at E.
  - If req_state != I and req_way equals the set's pointer, the pointer increments modulo WAYS at E.
  - A write produces no response; resp_valid=0 in the following cycle.
- Lookup accepted at edge E:
  - resp_* are valid during the cycle after E. resp_valid is high for exactly that one cycle per lookup.
  - The lookup sees every write accepted at or before E-1. A write at E-1 followed by a lookup at E to the same entry returns the new contents.
  - A write accepted at E+1 does not disturb the response of a lookup accepted at E, so response outputs are registered or otherwise isolated from later writes.
- Hit rule: a way hits when its state != I and its tag == req_tag.
  - If several ways hit (an illegal condition caused by the controller), resp_way is the lowest hitting way.
- On a miss:
  - resp_way is the lowest Invalid way if one exists, else the set's round-robin pointer.
  - resp_hit=0 and resp_state=0.
- The block performs no coherence transitions; the controller writes new states explicitly. Writing state I invalidates the entry.
- Reset asserted mid-INIT or mid-RUN:
  - Outputs clear immediately.
  - Any in-flight response is dropped.
  - The sweep restarts from set 0 when reset deasserts.
- The index wraps naturally; no bounds checking is done.

Test Plan:
- Reset, deassert, hold req_valid=1 throughout -> init_done and req_ready rise exactly 8 cycles after deassert (AWIDTH=3); no resp_valid at any point; every set then misses.
- After init, write idx=5 way=1 tag=0xABC state=S, lookup idx=5 tag=0xABC on the next cycle -> resp_valid=1, hit=1, way=1, state=1.
- Lookup idx=5 tag=0x123 with only way1 valid -> hit=0, way=0 (lowest Invalid), state=0.
- Fill idx=2 way0 then way1 with state M, then lookup a missing tag -> victim way=0 (pointer wrapped 0->1->0); write way0 again, miss -> way=1.
- Write idx=5 way=1 state=I, then lookup tag=0xABC -> hit=0, way=0 (lowest Invalid, since both ways are now I).
- Back-to-back lookup idx=3 then write idx=3 the next cycle -> the lookup response reflects the pre-write contents. Assert reset during that response cycle -> resp_valid drops immediately and the INIT sweep reruns.

Source files
------------

// File: rtl/tag_store_nway.sv
// N-way tag/state store for the L1 caches.
// Each set holds one {tag, MSI state} per way plus a round-robin victim pointer.
// After reset an internal sweep marks every way Invalid. After that, the block
// accepts one lookup or write per cycle. A lookup answers with hit/way/state
// one cycle after it is accepted.
module tag_store_nway #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 12,
  parameter int WWIDTH = 1,
  parameter int SWIDTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_index,
  input  logic [TWIDTH-1:0] req_tag,
  input  logic [WWIDTH-1:0] req_way,
  input  logic [SWIDTH-1:0] req_state,
  output logic              init_done,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WWIDTH-1:0] resp_way,
  output logic [SWIDTH-1:0] resp_state
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int WAYS  = 1 << WWIDTH;
  localparam logic [SWIDTH-1:0] ST_I = '0;

  typedef enum logic {INIT, RUN} fsm_t;

  fsm_t              fsm;
  logic [AWIDTH-1:0] sweep_cnt;

  logic [TWIDTH-1:0] tag_mem   [DEPTH][WAYS];
  logic [SWIDTH-1:0] state_mem [DEPTH][WAYS];
  logic [WWIDTH-1:0] rr_ptr    [DEPTH];

  logic              accept;
  logic              wr_en;
  logic              lk_en;
  logic              hit;
  logic [WWIDTH-1:0] hit_way;
  logic [SWIDTH-1:0] hit_state;
  logic              inv_found;
  logic [WWIDTH-1:0] inv_way;
  logic [WWIDTH-1:0] victim_way;

  assign accept = (fsm == RUN) && req_valid;
  assign wr_en  = accept && req_write;
  assign lk_en  = accept && !req_write;

  // Associative compare of the addressed set: lowest hitting way, lowest Invalid way.
  // NOTE: every output of this block gets a default before the loop, so no latch can be inferred.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_state = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    // Scanning from the top way down lets the lowest match overwrite the earlier ones.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (state_mem[req_index][WWIDTH'(w)] != ST_I &&
          tag_mem[req_index][WWIDTH'(w)] == req_tag) begin
        hit       = 1'b1;
        hit_way   = WWIDTH'(w);
        hit_state = state_mem[req_index][WWIDTH'(w)];
      end
      if (state_mem[req_index][WWIDTH'(w)] == ST_I) begin
        inv_found = 1'b1;
        inv_way   = WWIDTH'(w);
      end
    end
    victim_way = inv_found ? inv_way : rr_ptr[req_index];
  end

  // Control FSM: clear sweep, then registered lookup responses.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm        <= INIT;
      sweep_cnt  <= '0;
      init_done  <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_way   <= '0;
      resp_state <= '0;
    end else begin
      case (fsm)
        INIT: begin
          resp_valid <= 1'b0;
          sweep_cnt  <= sweep_cnt + AWIDTH'(1);
          if (sweep_cnt == AWIDTH'(DEPTH - 1)) begin
            fsm       <= RUN;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        RUN: begin
          resp_valid <= lk_en;
          // Response fields are captured at acceptance, so a later write cannot disturb them.
          if (lk_en) begin
            resp_hit   <= hit;
            resp_way   <= hit ? hit_way : victim_way;
            resp_state <= hit ? hit_state : ST_I;
          end
        end
      endcase
    end
  end

  // Storage update: sweep clears one set per cycle in INIT; accepted writes in RUN.
  // NOTE: the arrays have no reset; the sweep provides the only initialisation they need.
  always_ff @(posedge clock) begin
    if (fsm == INIT) begin
      for (int w = 0; w < WAYS; w++) begin
        state_mem[sweep_cnt][WWIDTH'(w)] <= ST_I;
      end
      rr_ptr[sweep_cnt] <= '0;
    end else if (wr_en) begin
      tag_mem[req_index][req_way]   <= req_tag;
      state_mem[req_index][req_way] <= req_state;
      if (req_state != ST_I && req_way == rr_ptr[req_index]) begin
        rr_ptr[req_index] <= rr_ptr[req_index] + WWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_tag_store_nway.sv
// Testbench for tag_store_nway (AWIDTH=3, WWIDTH=1).
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_tag_store_nway;

  localparam int AW    = 3;
  localparam int TW    = 12;
  localparam int WW    = 1;
  localparam int SW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int WAYS  = 1 << WW;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_index;
  logic [TW-1:0] req_tag;
  logic [WW-1:0] req_way;
  logic [SW-1:0] req_state;
  logic          init_done;
  logic          resp_valid;
  logic          resp_hit;
  logic [WW-1:0] resp_way;
  logic [SW-1:0] resp_state;

  int checks = 0;
  int errors = 0;

  tag_store_nway #(.AWIDTH(AW), .TWIDTH(TW), .WWIDTH(WW), .SWIDTH(SW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_index  (req_index),
    .req_tag    (req_tag),
    .req_way    (req_way),
    .req_state  (req_state),
    .init_done  (init_done),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_way   (resp_way),
    .resp_state (resp_state)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [TW-1:0] m_tag   [DEPTH][WAYS];
  int            m_state [DEPTH][WAYS];
  int            m_ptr   [DEPTH];

  task automatic model_clear();
    for (int s = 0; s < DEPTH; s++) begin
      for (int w = 0; w < WAYS; w++) m_state[s][w] = 0;
      m_ptr[s] = 0;
    end
  endtask

  task automatic model_write(input int idx, input int way, input logic [TW-1:0] tag, input int st);
    m_tag[idx][way]   = tag;
    m_state[idx][way] = st;
    if (st != 0 && way == m_ptr[idx]) m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
  endtask

  task automatic model_lookup(input int idx, input logic [TW-1:0] tag,
                              output bit hit, output int way, output int st);
    int hits[$];
    int invs[$];
    for (int w = 0; w < WAYS; w++) begin
      if (m_state[idx][w] != 0 && m_tag[idx][w] == tag) hits.push_back(w);
      if (m_state[idx][w] == 0) invs.push_back(w);
    end
    if (hits.size() > 0) begin
      hit = 1'b1;
      way = hits[0];
      st  = m_state[idx][way];
    end else begin
      hit = 1'b0;
      st  = 0;
      way = (invs.size() > 0) ? invs[0] : m_ptr[idx];
    end
  endtask

  // Drive one request at the falling edge; return at the next falling edge.
  task automatic do_op(input bit valid, input bit wr, input int idx, input logic [TW-1:0] tag,
                       input int way, input int st);
    req_valid = valid;
    req_write = wr;
    req_index = AW'(idx);
    req_tag   = tag;
    req_way   = WW'(way);
    req_state = SW'(st);
    @(negedge clock);
  endtask

  // Called at the falling edge where reset has just been released, with req_valid held high.
  task automatic init_sweep_check(input string tag_name);
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clock);
      check({tag_name, "_init_done"}, 32'(init_done), 32'(k == DEPTH));
      check({tag_name, "_req_ready"}, 32'(req_ready), 32'(k == DEPTH));
      check({tag_name, "_no_resp"}, 32'(resp_valid), 32'd0);
    end
  endtask

  typedef struct {
    bit            wr;
    int            idx;
    logic [TW-1:0] tag;
    int            way;
    int            st;
    bit            e_valid;
    bit            e_hit;
    int            e_way;
    int            e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit wr, input int idx, input logic [TW-1:0] tag, input int way,
                         input int st, input bit ev, input bit eh, input int ew, input int es);
    vec_t v;
    v.wr = wr; v.idx = idx; v.tag = tag; v.way = way; v.st = st;
    v.e_valid = ev; v.e_hit = eh; v.e_way = ew; v.e_st = es;
    vecs.push_back(v);
  endtask

  initial begin
    bit            mh;
    int            mw;
    int            ms;
    bit            wr;
    int            idx;
    int            way;
    int            st;
    logic [TW-1:0] tag;

    // Directed vectors, starting from a freshly swept store.
    //        wr  idx tag     way st  valid hit way st
    add_vec(0, 0, 12'h001, 0, 0, 1, 0, 0, 0);
    add_vec(0, 7, 12'hFFF, 0, 0, 1, 0, 0, 0);
    add_vec(1, 5, 12'hABC, 1, 1, 0, 0, 0, 0);
    add_vec(0, 5, 12'hABC, 0, 0, 1, 1, 1, 1);
    add_vec(0, 5, 12'h123, 0, 0, 1, 0, 0, 0);
    add_vec(1, 2, 12'h111, 0, 2, 0, 0, 0, 0);
    add_vec(1, 2, 12'h222, 1, 2, 0, 0, 0, 0);
    add_vec(0, 2, 12'h333, 0, 0, 1, 0, 0, 0);
    add_vec(1, 2, 12'h444, 0, 2, 0, 0, 0, 0);
    add_vec(0, 2, 12'h333, 0, 0, 1, 0, 1, 0);
    add_vec(0, 2, 12'h222, 0, 0, 1, 1, 1, 2);
    add_vec(1, 5, 12'hABC, 1, 0, 0, 0, 0, 0);
    add_vec(0, 5, 12'hABC, 0, 0, 1, 0, 0, 0);
    add_vec(1, 6, 12'h055, 0, 1, 0, 0, 0, 0);
    add_vec(1, 6, 12'h055, 1, 2, 0, 0, 0, 0);
    add_vec(0, 6, 12'h055, 0, 0, 1, 1, 0, 1);
    add_vec(1, 4, 12'h077, 0, 3, 0, 0, 0, 0);
    add_vec(0, 4, 12'h077, 0, 0, 1, 1, 0, 3);
    add_vec(0, 4, 12'h078, 0, 0, 1, 0, 1, 0);

    // Reset state.
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_index = '0; req_tag = '0; req_way = '0; req_state = '0;
    @(negedge clock);
    @(negedge clock);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_hit", 32'(resp_hit), 32'd0);
    check("rst_resp_way", 32'(resp_way), 32'd0);
    check("rst_resp_state", 32'(resp_state), 32'd0);

    // Release reset with a lookup held on the request port throughout the sweep.
    req_valid = 1'b1; req_write = 1'b0; req_index = 3'd1; req_tag = 12'h5A5;
    reset = 1'b0;
    init_sweep_check("sweep1");
    model_clear();

    // Every set misses after the sweep.
    for (int s = 0; s < DEPTH; s++) begin
      do_op(1, 0, s, TW'($urandom), 0, 0);
      check($sformatf("post_init_valid_s%0d", s), 32'(resp_valid), 32'd1);
      check($sformatf("post_init_hit_s%0d", s), 32'(resp_hit), 32'd0);
      check($sformatf("post_init_way_s%0d", s), 32'(resp_way), 32'd0);
      check($sformatf("post_init_state_s%0d", s), 32'(resp_state), 32'd0);
    end

    // Table-driven directed vectors.
    foreach (vecs[i]) begin
      do_op(1, vecs[i].wr, vecs[i].idx, vecs[i].tag, vecs[i].way, vecs[i].st);
      if (vecs[i].wr) model_write(vecs[i].idx, vecs[i].way, vecs[i].tag, vecs[i].st);
      check($sformatf("vec%0d_valid", i), 32'(resp_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_hit", i), 32'(resp_hit), 32'(vecs[i].e_hit));
        check($sformatf("vec%0d_way", i), 32'(resp_way), 32'(vecs[i].e_way));
        check($sformatf("vec%0d_state", i), 32'(resp_state), 32'(vecs[i].e_st));
      end
    end

    // Lookup followed immediately by a write to the same entry, then reset in the response cycle.
    do_op(1, 1, 3, 12'h0F0, 0, 1);
    model_write(3, 0, 12'h0F0, 1);
    do_op(1, 0, 3, 12'h0F0, 0, 0);
    req_valid = 1'b1; req_write = 1'b1; req_index = 3'd3; req_way = 1'b0; req_state = 2'd0;
    check("b2b_valid", 32'(resp_valid), 32'd1);
    check("b2b_hit", 32'(resp_hit), 32'd1);
    check("b2b_way", 32'(resp_way), 32'd0);
    check("b2b_state", 32'(resp_state), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_resp_hit", 32'(resp_hit), 32'd0);
    check("midrst_resp_state", 32'(resp_state), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    // Writes offered during the sweep must be ignored.
    req_valid = 1'b1; req_write = 1'b1; req_index = 3'd3; req_tag = 12'h0F0; req_way = 1'b0; req_state = 2'd2;
    reset = 1'b0;
    init_sweep_check("sweep2");
    model_clear();
    do_op(1, 0, 3, 12'h0F0, 0, 0);
    check("resweep_valid", 32'(resp_valid), 32'd1);
    check("resweep_hit", 32'(resp_hit), 32'd0);
    check("resweep_way", 32'(resp_way), 32'd0);

    // Randomized mix against the reference model.
    for (int n = 0; n < 400; n++) begin
      idx = int'($urandom_range(0, DEPTH - 1));
      way = int'($urandom_range(0, WAYS - 1));
      st  = int'($urandom_range(0, 3));
      tag = 12'h010 + TW'($urandom_range(0, 3));
      wr  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) begin
        do_op(0, wr, idx, tag, way, st);
        check($sformatf("rnd%0d_idle_valid", n), 32'(resp_valid), 32'd0);
      end else if (wr) begin
        do_op(1, 1, idx, tag, way, st);
        model_write(idx, way, tag, st);
        check($sformatf("rnd%0d_wr_valid", n), 32'(resp_valid), 32'd0);
      end else begin
        model_lookup(idx, tag, mh, mw, ms);
        do_op(1, 0, idx, tag, way, st);
        check($sformatf("rnd%0d_valid", n), 32'(resp_valid), 32'd1);
        check($sformatf("rnd%0d_hit", n), 32'(resp_hit), 32'(mh));
        check($sformatf("rnd%0d_way", n), 32'(resp_way), 32'(mw));
        check($sformatf("rnd%0d_state", n), 32'(resp_state), 32'(ms));
      end
    end

    req_valid = 1'b0;
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
